// File: rtl/traffic_pkg.sv
// Shared encodings for the intersection sequencer: state codes,
// state enum and {r,g,y} lamp bundles.
package traffic_pkg;

    localparam logic [2:0] A_GREEN   = 3'd0;
    localparam logic [2:0] A_YELLOW  = 3'd1;
    localparam logic [2:0] ALL_RED_A = 3'd2;
    localparam logic [2:0] B_GREEN   = 3'd3;
    localparam logic [2:0] B_YELLOW  = 3'd4;
    localparam logic [2:0] ALL_RED_B = 3'd5;

    typedef enum logic [2:0] {
        ST_A_GREEN   = A_GREEN,
        ST_A_YELLOW  = A_YELLOW,
        ST_ALL_RED_A = ALL_RED_A,
        ST_B_GREEN   = B_GREEN,
        ST_B_YELLOW  = B_YELLOW,
        ST_ALL_RED_B = ALL_RED_B
    } state_e;

    // One-hot lamp bundle ordered {r,g,y}
    typedef logic [2:0] lamp_t;

    localparam lamp_t LAMP_R = 3'b100;
    localparam lamp_t LAMP_G = 3'b010;
    localparam lamp_t LAMP_Y = 3'b001;

    // True for the two clearance states
    function automatic logic is_all_red(state_e s);
        return (s == ST_ALL_RED_A) || (s == ST_ALL_RED_B);
    endfunction

endpackage

// File: rtl/traffic_if.sv
// Sensor/lamp bundle between the sequencer (master) and the
// intersection (slave). emg exists only with TRAFFIC_CTRL_PREEMPT_EN.
interface traffic_if;

    logic       a_req;
    logic       b_req;
`ifdef TRAFFIC_CTRL_PREEMPT_EN
    logic       emg;
`endif
    logic       ar;
    logic       ag;
    logic       ay;
    logic       br;
    logic       bg;
    logic       by;
    logic [2:0] phase;

`ifdef TRAFFIC_CTRL_PREEMPT_EN
    modport master (
        input  a_req, b_req, emg,
        output ar, ag, ay, br, bg, by, phase
    );
    modport slave (
        output a_req, b_req, emg,
        input  ar, ag, ay, br, bg, by, phase
    );
`else
    modport master (
        input  a_req, b_req,
        output ar, ag, ay, br, bg, by, phase
    );
    modport slave (
        output a_req, b_req,
        input  ar, ag, ay, br, bg, by, phase
    );
`endif

endinterface

// File: rtl/phase_timer.sv
// Per-state cycle counter: clr_i restarts at 0 on state entry,
// hold_i parks it at 0, otherwise +1 per cycle saturating at LIMIT.
module phase_timer #(
    parameter int CNT_W = 8,
    parameter int LIMIT = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             hold_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] SAT = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || hold_i) begin
            cnt_d = '0;
        end else if (cnt_q != SAT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/traffic_controller.sv
// Six-phase Moore sequencer for a two-way intersection with min/max
// green, demand latching and (TRAFFIC_CTRL_PREEMPT_EN) emergency preempt.
// Ports: clk, rst_n (async, active-low), bus (traffic_if.master:
// a_req/b_req[/emg] in; ar,ag,ay,br,bg,by, phase[2:0] out).
module traffic_controller
    import traffic_pkg::*;
#(
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 8,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int CNT_W     = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    traffic_if.master bus
);

    localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(ALLRED_T - 1);

    state_e           state_q;
    state_e           state_d;
    logic             a_pend_q;
    logic             a_pend_d;
    logic             b_pend_q;
    logic             b_pend_d;
    logic [CNT_W-1:0] cnt;
    logic             preempt;
    logic             a_dem;
    logic             b_dem;
    logic             a_done;
    logic             b_done;
    logic             t_clr;
    logic             t_hold;
    lamp_t            lamp_a;
    lamp_t            lamp_b;

`ifdef TRAFFIC_CTRL_PREEMPT_EN
    assign preempt = bus.emg;
`else
    assign preempt = 1'b0;
`endif

    // Demand for an approach is the latch or the live sensor, so a
    // request arriving this cycle already counts.
    assign a_dem = a_pend_q | bus.a_req;
    assign b_dem = b_pend_q | bus.b_req;

    // Green may yield once min time is served, and only if its own
    // traffic has gone or the max time forces it out.
    assign a_done = (cnt >= GMIN_LAST) &&
                    (!bus.a_req || (cnt >= GMAX_LAST));
    assign b_done = (cnt >= GMIN_LAST) &&
                    (!bus.b_req || (cnt >= GMAX_LAST));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_A_GREEN: begin
                if (preempt || (b_dem && a_done)) begin
                    state_d = ST_A_YELLOW;
                end
            end
            ST_A_YELLOW: begin
                if (cnt == YEL_LAST) begin
                    state_d = ST_ALL_RED_A;
                end
            end
            ST_ALL_RED_A: begin
                if (!preempt && (cnt == AR_LAST)) begin
                    state_d = ST_B_GREEN;
                end
            end
            ST_B_GREEN: begin
                if (preempt || (a_dem && b_done)) begin
                    state_d = ST_B_YELLOW;
                end
            end
            ST_B_YELLOW: begin
                if (cnt == YEL_LAST) begin
                    state_d = ST_ALL_RED_B;
                end
            end
            ST_ALL_RED_B: begin
                if (!preempt && (cnt == AR_LAST)) begin
                    state_d = ST_A_GREEN;
                end
            end
            default: begin
                state_d = ST_ALL_RED_B;
            end
        endcase
    end

    // Latch demand while the approach is not green; entering its green
    // serves it, which takes priority over a same-cycle request.
    always_comb begin
        a_pend_d = a_pend_q | (bus.a_req & (state_q != ST_A_GREEN));
        b_pend_d = b_pend_q | (bus.b_req & (state_q != ST_B_GREEN));
        if ((state_d == ST_A_GREEN) && (state_q != ST_A_GREEN)) begin
            a_pend_d = 1'b0;
        end
        if ((state_d == ST_B_GREEN) && (state_q != ST_B_GREEN)) begin
            b_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_ALL_RED_B;
            a_pend_q <= 1'b0;
            b_pend_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_pend_q <= a_pend_d;
            b_pend_q <= b_pend_d;
        end
    end

    // Preempt parks all-red with the timer at zero so that ALLRED_T
    // full cycles follow once emg falls.
    assign t_clr  = (state_d != state_q);
    assign t_hold = preempt & is_all_red(state_q);

    phase_timer #(
        .CNT_W (CNT_W),
        .LIMIT (GREEN_MAX - 1)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (t_clr),
        .hold_i (t_hold),
        .cnt_o  (cnt)
    );

    // Lamps come straight from the state register: red unless this
    // approach owns the green or yellow phase.
    always_comb begin
        lamp_a = LAMP_R;
        lamp_b = LAMP_R;
        unique case (state_q)
            ST_A_GREEN:  lamp_a = LAMP_G;
            ST_A_YELLOW: lamp_a = LAMP_Y;
            ST_B_GREEN:  lamp_b = LAMP_G;
            ST_B_YELLOW: lamp_b = LAMP_Y;
            default: begin
                lamp_a = LAMP_R;
                lamp_b = LAMP_R;
            end
        endcase
    end

    assign bus.ar    = lamp_a[2];
    assign bus.ag    = lamp_a[1];
    assign bus.ay    = lamp_a[0];
    assign bus.br    = lamp_b[2];
    assign bus.bg    = lamp_b[1];
    assign bus.by    = lamp_b[0];
    assign bus.phase = state_q;

endmodule

// File: tb/tb_traffic_controller.sv
// Bench for traffic_controller: directed sequences with fixed
// expected phases plus random sensor traffic against a side/sub model.
module tb_traffic_controller;

    localparam int GREEN_MIN = 4;
    localparam int GREEN_MAX = 8;
    localparam int YELLOW_T  = 2;
    localparam int ALLRED_T  = 1;

    logic clk;
    logic rst_n;
    bit   a_req;
    bit   b_req;
    bit   emg_v;

    int n_vec;
    int n_err;

    traffic_if bus ();

    assign bus.a_req = a_req;
    assign bus.b_req = b_req;
`ifdef TRAFFIC_CTRL_PREEMPT_EN
    assign bus.emg = emg_v;
`endif

    traffic_controller #(
        .GREEN_MIN (GREEN_MIN),
        .GREEN_MAX (GREEN_MAX),
        .YELLOW_T  (YELLOW_T),
        .ALLRED_T  (ALLRED_T),
        .CNT_W     (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: side 0 = N-S, 1 = E-W; sub 0 green, 1 yellow, 2 all-red;
    // t = cycles already spent in the current phase (unbounded).
    typedef struct {
        int side;
        int sub;
        int t;
        bit pa;
        bit pb;
    } model_t;

    model_t m;

    function automatic model_t model_rst();
        model_t r;
        r.side = 1;
        r.sub  = 2;
        r.t    = 0;
        r.pa   = 1'b0;
        r.pb   = 1'b0;
        return r;
    endfunction

    function automatic model_t model_step(model_t c, bit ra, bit rb, bit e);
        model_t   n;
        bit [1:0] req;
        bit [1:0] pend;
        bit [1:0] np;
        int       oth;
        bit       leave;
        bit       green_now;
        bit       enter;
        n    = c;
        req  = {rb, ra};
        pend = {c.pb, c.pa};
        oth  = 1 - c.side;
        if (c.sub == 0) begin
            leave = e || ((pend[oth] || req[oth]) &&
                          (c.t >= GREEN_MIN - 1) &&
                          (!req[c.side] || (c.t >= GREEN_MAX - 1)));
        end else if (c.sub == 1) begin
            leave = (c.t == YELLOW_T - 1);
        end else begin
            leave = !e && (c.t == ALLRED_T - 1);
        end
        if (leave) begin
            n.t = 0;
            if (c.sub == 2) begin
                n.side = oth;
                n.sub  = 0;
            end else begin
                n.sub = c.sub + 1;
            end
        end else begin
            n.t = (c.sub == 2 && e) ? 0 : c.t + 1;
        end
        for (int s = 0; s < 2; s++) begin
            green_now = (c.sub == 0) && (c.side == s);
            enter = (n.sub == 0) && (n.side == s) && !green_now;
            np[s] = enter ? 1'b0 : (pend[s] | (req[s] & !green_now));
        end
        n.pa = np[0];
        n.pb = np[1];
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m <= model_rst();
        end else begin
            m <= model_step(m, a_req, b_req, emg_v);
        end
    end

    // {ar,ag,ay,br,bg,by} for an approach-level phase
    function automatic logic [5:0] lamps_of(int side, int sub);
        logic ag;
        logic ay;
        logic bg;
        logic by;
        ag = (side == 0) && (sub == 0);
        ay = (side == 0) && (sub == 1);
        bg = (side == 1) && (sub == 0);
        by = (side == 1) && (sub == 1);
        return {!(ag | ay), ag, ay, !(bg | by), bg, by};
    endfunction

    function automatic logic [5:0] dut_lamps();
        return {bus.ar, bus.ag, bus.ay, bus.br, bus.bg, bus.by};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected phase code at cycle k of each directed scenario
    function automatic int exp_phase(int which, int k);
        int p;
        p = 0;
        if (k == 0) begin
            p = 5;
        end else if (which == 1 || which == 3) begin
            if (k <= 4) p = 0;
            else if (k <= 6) p = 1;
            else if (k == 7) p = 2;
            else p = 3;
        end else if (which == 2) begin
            if (k <= 8) p = 0;
            else if (k <= 10) p = 1;
            else if (k == 11) p = 2;
            else if (k <= 19) p = 3;
            else if (k <= 21) p = 4;
            else if (k == 22) p = 5;
            else p = 0;
        end else if (which == 4) begin
            if (k <= 2) p = 0;
            else if (k <= 4) p = 1;
            else if (k <= 10) p = 2;
            else p = 3;
        end
        return p;
    endfunction

    // Leaves the bench at a negedge with reset just released: the next
    // rising edge is cycle 0.
    task automatic reset_seq();
        @(negedge clk);
        rst_n = 1'b0;
        a_req = 1'b0;
        b_req = 1'b0;
        emg_v = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_directed(input int which, input int len);
        int p;
        reset_seq();
        for (int k = 0; k < len; k++) begin
            if (k > 0) @(negedge clk);
            p = exp_phase(which, k);
            chk($sformatf("dir%0d_phase_c%0d", which, k),
                32'(bus.phase), 32'(p));
            chk($sformatf("dir%0d_lamps_c%0d", which, k),
                32'(dut_lamps()), 32'(lamps_of(p / 3, p % 3)));
            a_req = (which == 2) || (which == 4);
            b_req = (which == 1) || (which == 2) ||
                    ((which == 3) && (k == 2));
            emg_v = (which == 4) && (k >= 2) && (k <= 9);
        end
    endtask

    // Reset dropped in the middle of A_YELLOW, then a quiet restart
    task automatic run_mid_reset();
        reset_seq();
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("mid_phase_c%0d", k),
                32'(bus.phase), 32'(exp_phase(1, k)));
            b_req = 1'b1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_async_lamps", 32'(dut_lamps()), 32'(6'b100100));
        chk("mid_async_phase", 32'(bus.phase), 32'(5));
        b_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("mid_restart_c%0d", k),
                32'(bus.phase), 32'(exp_phase(0, k)));
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_lamps"}, 32'(dut_lamps()), 32'(lamps_of(m.side, m.sub)));
        chk({tag, "_phase"}, 32'(bus.phase), 32'(m.side * 3 + m.sub));
        chk({tag, "_excl"},
            32'((bus.ag | bus.ay) & (bus.bg | bus.by)), 32'(0));
    endtask

    task automatic run_random(input int segs, input int len);
        int da;
        int db;
        for (int s = 0; s < segs; s++) begin
            reset_seq();
            da = $urandom_range(0, 10);
            db = $urandom_range(0, 10);
            for (int k = 0; k < len; k++) begin
                if (k > 0) @(negedge clk);
                check_model($sformatf("rnd%0d_c%0d", s, k));
                a_req = ($urandom_range(0, 9) < da);
                b_req = ($urandom_range(0, 9) < db);
`ifdef TRAFFIC_CTRL_PREEMPT_EN
                if (emg_v) emg_v = ($urandom_range(0, 3) != 0);
                else emg_v = ($urandom_range(0, 29) == 0);
`endif
                if ($urandom_range(0, 199) == 0) begin
                    @(posedge clk);
                    #2;
                    rst_n = 1'b0;
                    #1;
                    chk("rnd_async_lamps", 32'(dut_lamps()), 32'(6'b100100));
                    @(negedge clk);
                    rst_n = 1'b1;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        assert (!((bus.ag | bus.ay) & (bus.bg | bus.by)))
            else $error("both approaches have right of way");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        a_req = 1'b0;
        b_req = 1'b0;
        emg_v = 1'b0;
        run_directed(0, 12);
        run_directed(1, 14);
        run_directed(2, 26);
        run_directed(3, 14);
        run_mid_reset();
`ifdef TRAFFIC_CTRL_PREEMPT_EN
        run_directed(4, 19);
`endif
        run_random(40, 120);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
